// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/CarryBypass_Adder.sv
// Carry-bypass adder: 4-bit ripple blocks whose carry-out is skipped straight
// from the block carry-in when every bit of the block propagates.
module CarryBypass_Adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int BLK = 4;

    function automatic logic [WIDTH:0] bypass_add(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             ci);
        logic [WIDTH-1:0] s;
        logic             c;
        logic             rc;
        logic             p;
        s = '0;
        c = ci;
        for (int blk = 0; blk < WIDTH / BLK; blk++) begin
            p  = 1'b1;
            rc = c;
            for (int i = 0; i < BLK; i++) begin
                p  = p & (x[blk*BLK+i] ^ y[blk*BLK+i]);
                s[blk*BLK+i] = x[blk*BLK+i] ^ y[blk*BLK+i] ^ rc;
                rc = (x[blk*BLK+i] & y[blk*BLK+i]) | (rc & (x[blk*BLK+i] ^ y[blk*BLK+i]));
            end
            // A fully propagating block passes its carry-in through unchanged.
            c = p ? c : rc;
        end
        return {c, s};
    endfunction

    always_comb begin
        {Cout, Sum} = bypass_add(A, B, Cin);
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned 32x32->64 multiplier: one shift-add iteration per clock through the
// carry-bypass adder, operands and product exchanged over valid/ready.
module seq_shift_add_multiplier #(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    import mult_pkg::*;

    localparam int ITERS = WIDTH;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid is held with stable data until that edge.
    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    assign addend = lo_q[0] ? mcand_q : '0;

    CarryBypass_Adder #(.WIDTH(WIDTH)) u_adder (
        .A    (hi_q),
        .B    (addend),
        .Cin  (1'b0),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC);
    assign product   = product_q;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    lo_d    = b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Adder carry becomes the new MSB; the sum LSB shifts into lo.
                hi_d  = {add_cout, add_sum[WIDTH-1:1]};
                lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d   = DONE;
                    product_d = {hi_d, lo_d};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier: vector table plus hand-written
// backpressure, reset-mid-operation and back-to-back sequences.
module tb_seq_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_shift_add_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; steps whole cycles until out_valid, bounded.
    task automatic wait_out_valid(input string name, output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check({name, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    // Called at a negedge with the DUT idle and out_ready high.
    task automatic run_op(input string name, input logic [31:0] op_a,
                          input logic [31:0] op_b, input logic [63:0] exp);
        int lat;
        check({name, "_in_ready_before"}, 64'(in_ready), 64'd1);
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        check({name, "_busy"}, 64'(busy), 64'd1);
        check({name, "_in_ready_calc"}, 64'(in_ready), 64'd0);
        wait_out_valid(name, lat);
        check({name, "_latency"}, 64'(lat), 64'd32);
        check({name, "_product"}, product, exp);
        @(posedge clk);
        @(negedge clk);
        check({name, "_out_valid_after"}, 64'(out_valid), 64'd0);
        check({name, "_in_ready_after"}, 64'(in_ready), 64'd1);
        check({name, "_product_held"}, product, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        vecs[0] = '{32'd7,          32'd6,          64'd42};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'd2147483647, 32'd2,          64'h0000_0000_FFFF_FFFE};
        vecs[3] = '{32'd0,          32'h1234_5678,  64'd0};
        vecs[4] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
        vecs[5] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
        vecs[6] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
        vecs[7] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};
        vecs[8] = '{32'hDEAD_BEEF,  32'd1,          64'h0000_0000_DEAD_BEEF};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_product", product, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("reset_release_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Backpressure with operand pulses ignored in CALC and DONE.
        out_ready = 1'b0;
        a         = 32'd12;
        b         = 32'd11;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_calc", 64'(in_ready), 64'd0);
        a = 32'd99;
        b = 32'd99;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid("bp", lat);
        check("bp_latency", 64'(lat), 64'd31);
        check("bp_product", product, 64'd132);
        a        = 32'd5;
        b        = 32'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_hold%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("bp_hold%0d_product", i), product, 64'd132);
            check($sformatf("bp_hold%0d_in_ready", i), 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_product", product, 64'd132);
        @(posedge clk);
        @(negedge clk);
        check("bp_single_transfer", 64'(out_valid), 64'd0);
        check("bp_no_ghost_busy", 64'(busy), 64'd0);

        // Reset in the middle of an operation.
        a        = 32'd100;
        b        = 32'd200;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rstmid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_out_valid", 64'(out_valid), 64'd0);
        check("rstmid_product", product, 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_in_ready_in_rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rstmid_in_ready", 64'(in_ready), 64'd1);
        run_op("after_rst", 32'd3, 32'd5, 64'd15);

        // Back-to-back with in_valid and out_ready held high.
        a        = 32'd1234;
        b        = 32'd5678;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b2b_first_busy", 64'(busy), 64'd1);
        a = 32'd9876;
        b = 32'd5432;
        wait_out_valid("b2b_first", lat);
        check("b2b_first_latency", 64'(lat), 64'd32);
        check("b2b_first_product", product, 64'd7006652);
        @(posedge clk);
        @(negedge clk);
        check("b2b_gap_out_valid", 64'(out_valid), 64'd0);
        check("b2b_gap_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_second_busy", 64'(busy), 64'd1);
        in_valid = 1'b0;
        wait_out_valid("b2b_second", lat);
        check("b2b_second_latency", 64'(lat), 64'd32);
        check("b2b_second_product", product, 64'd53646432);
        @(posedge clk);
        @(negedge clk);
        check("b2b_second_out_valid_after", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
